pc_fetch_unit: RTL and testbench

//  Program-counter register and instruction-fetch sequencer, directly downstream of pc_mux.

---
 rtl/pc_fetch_unit_if.sv | 19 +
 rtl/pc_fetch_unit.sv | 113 +++++++++++
 tb/tb_pc_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory port: valid/ready fetch request, valid-only response.
// master = fetch unit, slave = instruction memory.
interface pc_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rdata
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register + fetch sequencer: IDLE -> REQ -> WAIT -> EXEC -> REQ ..., HALT on fault.
// Optional response timeout: define FETCH_TIMEOUT_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            PC_data,
  input  logic                   stall,
  pc_fetch_unit_if.master        imem,
  output logic [31:0]            instr,
  output logic                   instr_valid,
  output logic [31:0]            PC,
  output logic [31:0]            PC_plus4,
  output logic                   misaligned,
  output logic                   fetch_timeout
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EXEC, S_HALT} state_t;

  state_t      state_q;
  logic [31:0] pc_q, instr_q;
  logic        req_vld_q, instr_vld_q, misal_q;
  logic        pc_ok_d;

  assign pc_ok_d = (PC_data[1:0] == 2'b00);

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_q;
`else
  logic unused_max_wait;
  assign unused_max_wait = (MAX_WAIT != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= NOP;
      req_vld_q   <= 1'b0;
      instr_vld_q <= 1'b0;
      misal_q     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q   <= S_REQ;
          req_vld_q <= 1'b1;
        end
        S_REQ: begin
          if (imem.imem_req_ready) begin
            state_q   <= S_WAIT;
            req_vld_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
          end
        end
        // A response arriving on the final counted cycle still wins over the timeout.
        S_WAIT: begin
          if (imem.imem_rsp_valid) begin
            instr_q     <= imem.imem_rdata;
            instr_vld_q <= 1'b1;
            state_q     <= S_EXEC;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= S_HALT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        S_EXEC: begin
          if (!stall) begin
            instr_vld_q <= 1'b0;
            if (pc_ok_d) begin
              pc_q      <= PC_data;
              req_vld_q <= 1'b1;
              state_q   <= S_REQ;
            end else begin
              misal_q <= 1'b1;
              state_q <= S_HALT;
            end
          end
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_HALT;
      endcase
    end
  end

  assign imem.imem_req_valid = req_vld_q;
  assign imem.imem_addr      = pc_q;
  assign PC                  = pc_q;
  assign PC_plus4            = pc_q + 32'd4;
  assign instr               = instr_q;
  assign instr_valid         = instr_vld_q;
  assign misaligned          = misal_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_timeout       = timeout_q;
`else
  assign fetch_timeout       = 1'b0;
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: expected fetch addresses queued by stimulus,
// checked at each request handshake and again when the instruction reaches decode.
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PC_data;
  logic        stall;
  logic [31:0] instr, PC, PC_plus4;
  logic        instr_valid, misaligned, fetch_timeout;

  pc_fetch_unit_if imem();

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_WAIT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PC_data      (PC_data),
    .stall        (stall),
    .imem         (imem),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .PC           (PC),
    .PC_plus4     (PC_plus4),
    .misaligned   (misaligned),
    .fetch_timeout(fetch_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] addr_q[$];
  logic [31:0] rsp_q[$];
  int rsp_lat = 1;
  bit rsp_en  = 1'b1;
  bit gap_chk = 1'b0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // memory: answers rsp_lat cycles after each handshake
  initial begin
    int wcnt;
    logic [31:0] la;
    wcnt = 0; la = '0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rdata     = '0;
    forever begin
      @(negedge clk);
      imem.imem_rsp_valid = 1'b0;
      if (wcnt > 0) begin
        wcnt--;
        if (wcnt == 0 && rsp_en) begin
          imem.imem_rsp_valid = 1'b1;
          imem.imem_rdata     = mem(la);
        end
      end
      if (rst_n && imem.imem_req_valid && imem.imem_req_ready) begin
        la   = imem.imem_addr;
        wcnt = rsp_lat;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic        iv_prev;
    int          last_hs;
    logic [31:0] ea;
    iv_prev = 1'b0; last_hs = -1;
    forever begin
      @(negedge clk);
      if (!gap_chk) last_hs = -1;
      if (!rst_n) begin
        rsp_q.delete();
        iv_prev = 1'b0;
      end else begin
        if (imem.imem_req_valid && imem.imem_req_ready) begin
          chk("req_expected", 32'(addr_q.size() != 0), 32'd1);
          if (addr_q.size() != 0) begin
            ea = addr_q.pop_front();
            chk("req_addr", imem.imem_addr, ea);
            rsp_q.push_back(ea);
          end
          if (gap_chk && last_hs >= 0) chk("req_gap", 32'(cyc - last_hs), 32'd3);
          last_hs = cyc;
        end
        if (instr_valid && !iv_prev) begin
          chk("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
          if (rsp_q.size() != 0) begin
            ea = rsp_q.pop_front();
            chk("dec_instr", instr, mem(ea));
            chk("dec_pc", PC, ea);
            chk("dec_pc4", PC_plus4, ea + 32'd4);
          end
        end
        iv_prev = instr_valid;
      end
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_pc"},   PC, 32'h0);
    chk({tag, "_pc4"},  PC_plus4, 32'h4);
    chk({tag, "_addr"}, imem.imem_addr, 32'h0);
    chk({tag, "_ins"},  instr, 32'h0000_0013);
    chk({tag, "_iv"},   32'(instr_valid), 32'd0);
    chk({tag, "_rv"},   32'(imem.imem_req_valid), 32'd0);
    chk({tag, "_mis"},  32'(misaligned), 32'd0);
    chk({tag, "_tmo"},  32'(fetch_timeout), 32'd0);
  endtask

  task automatic wait_exec(input string tag);
    for (int i = 0; i < 60 && !instr_valid; i++) begin
      @(posedge clk); #1;
    end
    if (!instr_valid) chk({tag, "_wait"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20 && !imem.imem_req_valid; i++) begin
      @(posedge clk); #1;
    end
    if (!imem.imem_req_valid) chk({tag, "_wait"}, 32'(imem.imem_req_valid), 32'd1);
  endtask

  task automatic fetch_next(input logic [31:0] nxt);
    wait_exec("exec");
    PC_data = nxt;
    addr_q.push_back(nxt);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; PC_data = '0; stall = 1'b0;
    imem.imem_req_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst0");

    // reset while a fetch is outstanding; the late response lands during reset
    rsp_lat = 8;
    addr_q.push_back(32'h0);
    rst_n = 1'b1;
    wait_req("rq0");
    @(posedge clk); #1;
    chk("wait_rv", 32'(imem.imem_req_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    reset_checks("rst_wait");
    addr_q.delete();
    repeat (10) @(posedge clk);
    #1;

    // straight-line 0,4,8 at one fetch per 3 cycles
    rsp_lat = 1;
    addr_q.push_back(32'h0);
    gap_chk = 1'b1;
    rst_n   = 1'b1;
    fetch_next(32'h4);
    fetch_next(32'h8);
    wait_exec("exec8");
    gap_chk = 1'b0;

    // stall holds EXEC; PC_data presented during stall is not sampled
    stall = 1'b1; PC_data = 32'h42;
    repeat (4) begin
      @(posedge clk); #1;
      chk("stall_iv", 32'(instr_valid), 32'd1);
      chk("stall_pc", PC, 32'h8);
      chk("stall_ins", instr, mem(32'h8));
    end
    stall = 1'b0;
    fetch_next(32'h40);
    chk("stall_mis", 32'(misaligned), 32'd0);

    // back-pressure on the request
    wait_exec("exec40");
    imem.imem_req_ready = 1'b0;
    fetch_next(32'h10);
    repeat (5) begin
      chk("bp_rv", 32'(imem.imem_req_valid), 32'd1);
      chk("bp_addr", imem.imem_addr, 32'h10);
      @(posedge clk); #1;
    end
    imem.imem_req_ready = 1'b1;

    // wrap at top of address space, multi-cycle response
    wait_exec("exec10");
    rsp_lat = 3;
    fetch_next(32'hFFFF_FFFC);
    wait_exec("execwrap");
    chk("wrap_pc4", PC_plus4, 32'h0);

    // misaligned target halts the core
    PC_data = 32'h0000_0042;
    @(posedge clk); #1;
    chk("mis_flag", 32'(misaligned), 32'd1);
    chk("mis_pc", PC, 32'hFFFF_FFFC);
    repeat (6) begin
      @(posedge clk); #1;
      chk("halt_iv", 32'(instr_valid), 32'd0);
      chk("halt_rv", 32'(imem.imem_req_valid), 32'd0);
    end
    chk("halt_tmo", 32'(fetch_timeout), 32'd0);

    rst_n = 1'b0;
    addr_q.delete();
    repeat (2) @(posedge clk);
    #1;
`ifdef FETCH_TIMEOUT_EN
    // no response: timeout after the 16th waiting cycle
    rsp_en = 1'b0;
    addr_q.push_back(32'h0);
    rst_n = 1'b1;
    wait_req("rq_to");
    @(posedge clk); #1;
    repeat (15) begin @(posedge clk); #1; end
    chk("to_early", 32'(fetch_timeout), 32'd0);
    @(posedge clk); #1;
    chk("to_flag", 32'(fetch_timeout), 32'd1);
    chk("to_iv", 32'(instr_valid), 32'd0);
    chk("to_rv", 32'(imem.imem_req_valid), 32'd0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // response on the 16th waiting cycle is captured
    rsp_en = 1'b1; rsp_lat = 16;
    addr_q.push_back(32'h0);
    rst_n = 1'b1;
    wait_req("rq_16");
    @(posedge clk); #1;
    repeat (16) begin @(posedge clk); #1; end
    chk("rsp16_iv", 32'(instr_valid), 32'd1);
    chk("rsp16_tmo", 32'(fetch_timeout), 32'd0);
`else
    // without the timeout a slow response is still accepted
    rsp_lat = 20;
    addr_q.push_back(32'h0);
    rst_n = 1'b1;
    wait_exec("slow");
    chk("slow_ins", instr, mem(32'h0));
    chk("slow_tmo", 32'(fetch_timeout), 32'd0);
`endif
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1);
  end
endmodule
